gen_branch_alu: RTL and testbench
=================================

// Module: gen_branch_alu
// PURPOSE
//  Execute-stage arithmetic unit of the ysyx_22051468 RV64 core: general integer ALU (GenAlu) plus branch comparator (BranchAlu).
//  GenAlu serves OP/OP-IMM/-W ops and address adds for AUIPC/JAL/JALR/branch targets; BranchAlu decides B-type taken.
//  Both are computed combinationally and registered once; Exec consumes the registered results.
// PARAMETERS
//  WIDTH             64  datapath width (XLEN)
//  ALU_OPCODE_WIDTH  10  one-hot opcode width (= EXPLICIT_TYPE_NUM)
// PORTS
//  clk           in   1                 rising-edge clock
//  rst_n         in   1                 asynchronous active-low reset
//  alu_ena       in   1                 GenAlu operation valid this cycle
//  alu_op1       in   WIDTH             GenAlu operand 1 (rs1 or pc)
//  alu_op2       in   WIDTH             GenAlu operand 2 (rs2 or imm)
//  alu_opcode    in   ALU_OPCODE_WIDTH  one-hot GenAlu op
//  is_U_i        in   1                 unsigned variant (SLTU, BLTU/BGEU)
//  is_W_i        in   1                 32-bit -W variant (GenAlu only)
//  br_ena        in   1                 BranchAlu operation valid
//  br_op1        in   WIDTH             rs1
//  br_op2        in   WIDTH             rs2
//  br_opcode     in   ALU_OPCODE_WIDTH  one-hot branch condition
//  out_result    out  WIDTH             registered GenAlu result
//  overflow      out  1                 signed overflow of ADD/SUB at operating width
//  zero          out  1                 out_result == 0 (only when alu_ena)
//  carry         out  1                 unsigned carry-out (ADD) / borrow (SUB)
//  slt_out       out  1                 op1 < op2 (signed, or unsigned if is_U_i)
//  branch_jump   out  1                 branch taken
//  out_valid     out  1                 alu_ena|br_ena of previous cycle
// BEHAVIOUR
//  - Reset (rst_n=0, async): every output 0; held while low. Release is synchronous to clk.
//  - Latency: inputs sampled at posedge N, outputs valid after posedge N; no stall, no handshake; new op every cycle.
//  - alu_opcode bits: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 XOR, 5 SRL, 6 SRA, 7 OR, 8 AND, 9 reserved.
//  - br_opcode bits: 0 EQ, 1 NE, 2 LT, 3 GE; is_U_i turns LT/GE into LTU/GEU.
//  - opcode zero, multi-hot or reserved -> out_result=0, flags=0 (branch: not taken).
//  - alu_ena=0 -> out_result/overflow/zero/carry/slt_out registered as 0.
//  - br_ena=0 -> branch_jump registered as 0.
//  - 64-bit: shamt = op2[5:0]; ADD/SUB wrap modulo 2^64.
//  - is_W_i=1: compute on op1[31:0]/op2[31:0]; shamt = op2[4:0]; SRA uses op1[31] as fill.
//    The 32-bit result is sign-extended from bit 31 (all ops incl. SRLW). overflow/carry refer to bit 31.
//  - SLT/SLTU result = {63'b0, lt}; is_U_i ignored for other GenAlu ops.
//  - overflow = (op1 sign == op2' sign) & (result sign != op1 sign), where op2' = ~op2+1 for SUB.
//  - Simultaneous alu_ena and br_ena are independent and both legal (pc+imm target alongside rs1/rs2 compare).
// STRUCTURE
//  - Shared package ysyx_22051468_alu_pkg: ALU_OPCODE_WIDTH, GenAlu bit indices (ALU_ADD..ALU_AND), branch indices (BR_EQ..BR_GE).
//  - One sub-module br_cmp (combinational): EQ/NE/LT/GE signed/unsigned -> taken.
//    GenAlu datapath is inline; one shared adder/subtractor feeds ADD, SUB, SLT and the flags.
// TESTING
//  1 Reset: drive rst_n=0 mid-operation -> all outputs 0 immediately, without waiting for clk; rst_n=1 then ADD 1+2 -> out_result=3 next cycle, out_valid=1.
//  2 ADD 0x7FFF_FFFF_FFFF_FFFF+1 -> 0x8000_0000_0000_0000, overflow=1, carry=0; SUB 0-1 -> all-ones, carry=1.
//  3 W ops: ADDW 0x7FFF_FFFF+1 -> 0xFFFF_FFFF_8000_0000; SRAW 0x8000_0000>>4 -> 0xFFFF_FFFF_F800_0000; SLLW shamt=33 uses 1.
//  4 SLT/SLTU op1=-1, op2=1: signed -> 1, is_U_i=1 -> 0; SRA -8>>1 -> -4, SRL -> 0x7FFF_FFFF_FFFF_FFFC.
//  5 Branch with br_ena=1, op1=-1, op2=1: BLT taken, BLTU not; BGE/BGEU inverse; BEQ 5,5 taken; BNE 5,5 not.
//    br_ena=0 -> branch_jump=0.
//  6 Illegal opcodes (0, 0b11, bit 9) and alu_ena=0 -> out_result=0, all flags 0.
//    Back-to-back ops on consecutive cycles each appear exactly one cycle later.

Source files
------------

// File: rtl/gen_branch_alu_pkg.sv
// Shared constants and types for the execute-stage GenAlu / BranchAlu pair.
package ysyx_22051468_alu_pkg;

  // One-hot opcode width, shared by the GenAlu and the branch comparator.
  localparam int unsigned ALU_OPCODE_WIDTH = 10;

  // GenAlu one-hot bit positions.
  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;
  localparam int unsigned ALU_SLL = 2;
  localparam int unsigned ALU_SLT = 3;
  localparam int unsigned ALU_XOR = 4;
  localparam int unsigned ALU_SRL = 5;
  localparam int unsigned ALU_SRA = 6;
  localparam int unsigned ALU_OR  = 7;
  localparam int unsigned ALU_AND = 8;
  localparam int unsigned ALU_RSV = 9;

  // BranchAlu one-hot bit positions; is_U_i turns LT/GE into LTU/GEU.
  localparam int unsigned BR_EQ = 0;
  localparam int unsigned BR_NE = 1;
  localparam int unsigned BR_LT = 2;
  localparam int unsigned BR_GE = 3;

  typedef logic [ALU_OPCODE_WIDTH-1:0] alu_opcode_t;

  // Bits each unit is allowed to see set; anything else is an illegal opcode.
  localparam alu_opcode_t ALU_LEGAL_MASK = 10'h1FF;
  localparam alu_opcode_t BR_LEGAL_MASK  = 10'h00F;

  typedef struct packed {
    logic overflow;
    logic zero;
    logic carry;
    logic slt;
  } alu_flags_t;

  // True when exactly one bit is set and it lies inside the legal mask.
  function automatic logic op_is_legal(input alu_opcode_t op, input alu_opcode_t mask);
    return (op != '0) && ((op & (op - alu_opcode_t'(1))) == '0) && ((op & ~mask) == '0);
  endfunction

endpackage

// File: rtl/gen_branch_alu_br_cmp.sv
// Combinational branch comparator: EQ/NE/LT/GE (signed or unsigned) -> taken.
module br_cmp #(
  parameter int unsigned WIDTH            = 64,
  parameter int unsigned ALU_OPCODE_WIDTH = ysyx_22051468_alu_pkg::ALU_OPCODE_WIDTH
) (
  input  logic [WIDTH-1:0]            op1_i,
  input  logic [WIDTH-1:0]            op2_i,
  input  logic [ALU_OPCODE_WIDTH-1:0] opcode_i,
  input  logic                        is_u_i,
  output logic                        taken_o
);
  import ysyx_22051468_alu_pkg::*;

  logic legal;
  logic eq;
  logic lt;

  assign legal = op_is_legal(opcode_i, BR_LEGAL_MASK);
  assign eq    = (op1_i == op2_i);
  assign lt    = is_u_i ? (op1_i < op2_i) : ($signed(op1_i) < $signed(op2_i));

  // Select the condition named by the one-hot opcode; illegal opcodes never branch.
  always_comb begin
    taken_o = 1'b0;
    if (legal) begin
      unique case (1'b1)
        opcode_i[BR_EQ]: taken_o = eq;
        opcode_i[BR_NE]: taken_o = ~eq;
        opcode_i[BR_LT]: taken_o = lt;
        opcode_i[BR_GE]: taken_o = ~lt;
        default:         taken_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/gen_branch_alu.sv
// Execute-stage GenAlu plus BranchAlu; both results are registered once.
module gen_branch_alu #(
  parameter int unsigned WIDTH            = 64,
  parameter int unsigned ALU_OPCODE_WIDTH = ysyx_22051468_alu_pkg::ALU_OPCODE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        alu_ena,
  input  logic [WIDTH-1:0]            alu_op1,
  input  logic [WIDTH-1:0]            alu_op2,
  input  logic [ALU_OPCODE_WIDTH-1:0] alu_opcode,
  input  logic                        is_U_i,
  input  logic                        is_W_i,
  input  logic                        br_ena,
  input  logic [WIDTH-1:0]            br_op1,
  input  logic [WIDTH-1:0]            br_op2,
  input  logic [ALU_OPCODE_WIDTH-1:0] br_opcode,
  output logic [WIDTH-1:0]            out_result,
  output logic                        overflow,
  output logic                        zero,
  output logic                        carry,
  output logic                        slt_out,
  output logic                        branch_jump,
  output logic                        out_valid
);
  import ysyx_22051468_alu_pkg::*;

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam int unsigned HiW = WIDTH - 32;

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  logic op_valid;
  logic is_add;
  logic is_sub;
  logic is_slt;
  logic use_sub;

  assign op_valid = alu_ena & op_is_legal(alu_opcode, ALU_LEGAL_MASK);
  assign is_add   = alu_opcode[ALU_ADD];
  assign is_sub   = alu_opcode[ALU_SUB];
  assign is_slt   = alu_opcode[ALU_SLT];
  // SLT/SLTU reuse the subtractor to form the comparison.
  assign use_sub  = is_sub | is_slt;

  // ---------------------------------------------------------------------------
  // Shared adder/subtractor
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] op2_inv;
  logic [WIDTH:0]   sum;
  logic             cout;
  logic             a_sign;
  logic             b_sign;
  logic             r_sign;
  logic             b_low_zero;
  logic             b_eff_sign;
  logic             ovf_raw;
  logic             lt;

  assign op2_inv = alu_op2 ^ {WIDTH{use_sub}};
  assign sum     = {1'b0, alu_op1} + {1'b0, op2_inv} + (WIDTH + 1)'(use_sub);

  // In -W mode the carry out of bit 31 is recovered from bit 32 of the full-width sum.
  assign cout    = is_W_i ? (sum[32] ^ alu_op1[32] ^ op2_inv[32]) : sum[WIDTH];

  assign a_sign  = is_W_i ? alu_op1[31] : alu_op1[WIDTH-1];
  assign b_sign  = is_W_i ? alu_op2[31] : alu_op2[WIDTH-1];
  assign r_sign  = is_W_i ? sum[31]     : sum[WIDTH-1];

  // Sign of (~op2 + 1): flips op2's sign unless every bit below the sign is zero.
  assign b_low_zero = is_W_i ? (alu_op2[30:0] == '0) : (alu_op2[WIDTH-2:0] == '0);
  assign b_eff_sign = use_sub ? (b_low_zero ? b_sign : ~b_sign) : b_sign;

  assign ovf_raw = (a_sign == b_eff_sign) & (r_sign != a_sign);
  // Unsigned less-than is the subtract borrow; signed uses sign bits then result sign.
  assign lt      = is_U_i ? ~cout : ((a_sign != b_sign) ? a_sign : r_sign);

  // ---------------------------------------------------------------------------
  // Shifter
  // ---------------------------------------------------------------------------
  logic [ShW-1:0]          shamt;
  logic [WIDTH-1:0]        srl_src;
  logic signed [WIDTH-1:0] sra_src;
  logic [WIDTH-1:0]        sll_res;
  logic [WIDTH-1:0]        srl_res;
  logic [WIDTH-1:0]        sra_res;

  assign shamt   = is_W_i ? ShW'(alu_op2[4:0]) : alu_op2[ShW-1:0];
  assign srl_src = is_W_i ? {{HiW{1'b0}}, alu_op1[31:0]} : alu_op1;
  assign sra_src = is_W_i ? {{HiW{alu_op1[31]}}, alu_op1[31:0]} : alu_op1;
  assign sll_res = alu_op1 << shamt;
  assign srl_res = srl_src >> shamt;
  assign sra_res = sra_src >>> shamt;

  // ---------------------------------------------------------------------------
  // Result select and flags
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] raw_res;
  logic [WIDTH-1:0] result_d;
  alu_flags_t       flags_d;

  // Pick the result of the single active op; illegal or idle yields zero.
  always_comb begin
    raw_res = '0;
    if (op_valid) begin
      unique case (1'b1)
        alu_opcode[ALU_ADD]: raw_res = sum[WIDTH-1:0];
        alu_opcode[ALU_SUB]: raw_res = sum[WIDTH-1:0];
        alu_opcode[ALU_SLL]: raw_res = sll_res;
        alu_opcode[ALU_SLT]: raw_res = WIDTH'(lt);
        alu_opcode[ALU_XOR]: raw_res = alu_op1 ^ alu_op2;
        alu_opcode[ALU_SRL]: raw_res = srl_res;
        alu_opcode[ALU_SRA]: raw_res = sra_res;
        alu_opcode[ALU_OR]:  raw_res = alu_op1 | alu_op2;
        alu_opcode[ALU_AND]: raw_res = alu_op1 & alu_op2;
        default:             raw_res = '0;
      endcase
    end
  end

  // -W results are always sign-extended from bit 31, SRLW included.
  assign result_d = is_W_i ? {{HiW{raw_res[31]}}, raw_res[31:0]} : raw_res;

  // Flags are qualified by the op that defines them.
  always_comb begin
    flags_d          = '0;
    flags_d.overflow = op_valid & (is_add | is_sub) & ovf_raw;
    flags_d.carry    = op_valid & (is_add | is_sub) & (is_sub ? ~cout : cout);
    flags_d.slt      = op_valid & is_slt & lt;
    flags_d.zero     = op_valid & (result_d == '0);
  end

  // ---------------------------------------------------------------------------
  // Branch comparator
  // ---------------------------------------------------------------------------
  logic br_taken;

  br_cmp #(
    .WIDTH            (WIDTH),
    .ALU_OPCODE_WIDTH (ALU_OPCODE_WIDTH)
  ) u_br_cmp (
    .op1_i    (br_op1),
    .op2_i    (br_op2),
    .opcode_i (br_opcode),
    .is_u_i   (is_U_i),
    .taken_o  (br_taken)
  );

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic             branch_q;
  logic             valid_q;

  // Single pipeline stage; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      flags_q  <= '0;
      branch_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
      branch_q <= br_ena & br_taken;
      valid_q  <= alu_ena | br_ena;
    end
  end

  assign out_result  = result_q;
  assign overflow    = flags_q.overflow;
  assign zero        = flags_q.zero;
  assign carry       = flags_q.carry;
  assign slt_out     = flags_q.slt;
  assign branch_jump = branch_q;
  assign out_valid   = valid_q;

endmodule

// File: tb/tb_gen_branch_alu.sv
// Directed-vector bench for gen_branch_alu.
module tb_gen_branch_alu;

  localparam logic [9:0] OpAdd = 10'h001;
  localparam logic [9:0] OpSub = 10'h002;
  localparam logic [9:0] OpSll = 10'h004;
  localparam logic [9:0] OpSlt = 10'h008;
  localparam logic [9:0] OpXor = 10'h010;
  localparam logic [9:0] OpSrl = 10'h020;
  localparam logic [9:0] OpSra = 10'h040;
  localparam logic [9:0] OpOr  = 10'h080;
  localparam logic [9:0] OpAnd = 10'h100;
  localparam logic [9:0] BrEq  = 10'h001;
  localparam logic [9:0] BrNe  = 10'h002;
  localparam logic [9:0] BrLt  = 10'h004;
  localparam logic [9:0] BrGe  = 10'h008;

  logic        clk;
  logic        rst_n;
  logic        alu_ena;
  logic [63:0] alu_op1;
  logic [63:0] alu_op2;
  logic [9:0]  alu_opcode;
  logic        is_u;
  logic        is_w;
  logic        br_ena;
  logic [63:0] br_op1;
  logic [63:0] br_op2;
  logic [9:0]  br_opcode;
  logic [63:0] out_result;
  logic        overflow;
  logic        zero;
  logic        carry;
  logic        slt_out;
  logic        branch_jump;
  logic        out_valid;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  gen_branch_alu #(
    .WIDTH            (64),
    .ALU_OPCODE_WIDTH (10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_ena     (alu_ena),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_opcode  (alu_opcode),
    .is_U_i      (is_u),
    .is_W_i      (is_w),
    .br_ena      (br_ena),
    .br_op1      (br_op1),
    .br_op2      (br_op2),
    .br_opcode   (br_opcode),
    .out_result  (out_result),
    .overflow    (overflow),
    .zero        (zero),
    .carry       (carry),
    .slt_out     (slt_out),
    .branch_jump (branch_jump),
    .out_valid   (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] flags_now();
    return {60'd0, overflow, zero, carry, slt_out};
  endfunction

  // exp_fl = {overflow, zero, carry, slt}
  task automatic alu_vec(input string tag, input logic [63:0] op1, input logic [63:0] op2,
                         input logic [9:0] opc, input logic u, input logic w,
                         input logic [63:0] exp_res, input logic [3:0] exp_fl);
    alu_ena    = 1'b1;
    br_ena     = 1'b0;
    alu_op1    = op1;
    alu_op2    = op2;
    alu_opcode = opc;
    is_u       = u;
    is_w       = w;
    @(posedge clk);
    #1;
    check({tag, "/res"}, out_result, exp_res);
    check({tag, "/flags"}, flags_now(), {60'd0, exp_fl});
    check({tag, "/valid"}, {63'd0, out_valid}, 64'd1);
  endtask

  task automatic br_vec(input string tag, input logic [63:0] op1, input logic [63:0] op2,
                        input logic [9:0] opc, input logic u, input logic ena,
                        input logic exp_taken);
    alu_ena   = 1'b0;
    br_ena    = ena;
    br_op1    = op1;
    br_op2    = op2;
    br_opcode = opc;
    is_u      = u;
    is_w      = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "/taken"}, {63'd0, branch_jump}, {63'd0, exp_taken});
    check({tag, "/valid"}, {63'd0, out_valid}, {63'd0, ena});
    check({tag, "/res"}, out_result, 64'd0);
    check({tag, "/flags"}, flags_now(), 64'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    alu_ena    = 1'b0;
    alu_op1    = '0;
    alu_op2    = '0;
    alu_opcode = '0;
    is_u       = 1'b0;
    is_w       = 1'b0;
    br_ena     = 1'b0;
    br_op1     = '0;
    br_op2     = '0;
    br_opcode  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst0/res", out_result, 64'd0);
    check("rst0/valid", {63'd0, out_valid}, 64'd0);
    rst_n = 1'b1;

    alu_vec("add5_7", 64'd5, 64'd7, OpAdd, 1'b0, 1'b0, 64'd12, 4'b0000);

    // Mid-operation async reset, then recovery
    alu_ena    = 1'b1;
    alu_op1    = 64'd1;
    alu_op2    = 64'd2;
    alu_opcode = OpAdd;
    br_ena     = 1'b1;
    br_op1     = 64'd5;
    br_op2     = 64'd5;
    br_opcode  = BrEq;
    @(posedge clk);
    #1;
    check("pre_rst/res", out_result, 64'd3);
    check("pre_rst/taken", {63'd0, branch_jump}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst/res", out_result, 64'd0);
    check("async_rst/taken", {63'd0, branch_jump}, 64'd0);
    check("async_rst/valid", {63'd0, out_valid}, 64'd0);
    check("async_rst/flags", flags_now(), 64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst/res", out_result, 64'd3);
    check("post_rst/valid", {63'd0, out_valid}, 64'd1);

    // 64-bit arithmetic boundaries
    alu_vec("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OpAdd, 1'b0, 1'b0,
            64'h8000_0000_0000_0000, 4'b1000);
    alu_vec("sub_0_1", 64'd0, 64'd1, OpSub, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
    alu_vec("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OpAdd, 1'b0, 1'b0, 64'd0, 4'b0110);

    // -W ops
    alu_vec("addw_ovf", 64'h0000_0000_7FFF_FFFF, 64'd1, OpAdd, 1'b0, 1'b1,
            64'hFFFF_FFFF_8000_0000, 4'b1000);
    alu_vec("sraw", 64'h0000_0000_8000_0000, 64'd4, OpSra, 1'b0, 1'b1,
            64'hFFFF_FFFF_F800_0000, 4'b0000);
    alu_vec("sllw_33", 64'd1, 64'd33, OpSll, 1'b0, 1'b1, 64'd2, 4'b0000);
    alu_vec("srlw_0", 64'h0000_0000_8000_0000, 64'd0, OpSrl, 1'b0, 1'b1,
            64'hFFFF_FFFF_8000_0000, 4'b0000);

    // Compares and shifts
    alu_vec("slt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OpSlt, 1'b0, 1'b0, 64'd1, 4'b0001);
    alu_vec("sltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, OpSlt, 1'b1, 1'b0, 64'd0, 4'b0100);
    alu_vec("sra", 64'hFFFF_FFFF_FFFF_FFF8, 64'd1, OpSra, 1'b0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFC, 4'b0000);
    alu_vec("srl", 64'hFFFF_FFFF_FFFF_FFF8, 64'd1, OpSrl, 1'b0, 1'b0,
            64'h7FFF_FFFF_FFFF_FFFC, 4'b0000);
    alu_vec("sll_63", 64'd1, 64'd63, OpSll, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 4'b0000);
    alu_vec("sll_64", 64'd1, 64'd64, OpSll, 1'b0, 1'b0, 64'd1, 4'b0000);
    alu_vec("xor", 64'hF0F0, 64'hFF00, OpXor, 1'b0, 1'b0, 64'h0FF0, 4'b0000);
    alu_vec("or", 64'hF0F0, 64'hFF00, OpOr, 1'b0, 1'b0, 64'hFFF0, 4'b0000);
    alu_vec("and", 64'hF0F0, 64'hFF00, OpAnd, 1'b0, 1'b0, 64'hF000, 4'b0000);

    // Branch conditions
    br_vec("blt", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, BrLt, 1'b0, 1'b1, 1'b1);
    br_vec("bltu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, BrLt, 1'b1, 1'b1, 1'b0);
    br_vec("bge", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, BrGe, 1'b0, 1'b1, 1'b0);
    br_vec("bgeu", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, BrGe, 1'b1, 1'b1, 1'b1);
    br_vec("beq", 64'd5, 64'd5, BrEq, 1'b0, 1'b1, 1'b1);
    br_vec("bne", 64'd5, 64'd5, BrNe, 1'b0, 1'b1, 1'b0);
    br_vec("br_off", 64'd5, 64'd5, BrEq, 1'b0, 1'b0, 1'b0);
    br_vec("br_illegal", 64'd5, 64'd5, 10'h003, 1'b0, 1'b1, 1'b0);

    // Illegal GenAlu opcodes
    alu_vec("op_zero", 64'd1, 64'd2, 10'h000, 1'b0, 1'b0, 64'd0, 4'b0000);
    alu_vec("op_multi", 64'd1, 64'd2, 10'h003, 1'b0, 1'b0, 64'd0, 4'b0000);
    alu_vec("op_rsv", 64'd1, 64'd2, 10'h200, 1'b0, 1'b0, 64'd0, 4'b0000);

    // alu_ena=0 with a legal ADD still on the operands
    alu_op1    = 64'd1;
    alu_op2    = 64'd2;
    alu_opcode = OpAdd;
    br_vec("alu_off", 64'd0, 64'd0, BrEq, 1'b0, 1'b0, 1'b0);

    // Simultaneous target add and compare
    alu_ena    = 1'b1;
    alu_op1    = 64'h1000;
    alu_op2    = 64'h20;
    alu_opcode = OpAdd;
    is_u       = 1'b0;
    is_w       = 1'b0;
    br_ena     = 1'b1;
    br_op1     = 64'd3;
    br_op2     = 64'd4;
    br_opcode  = BrNe;
    @(posedge clk);
    #1;
    check("dual/res", out_result, 64'h1020);
    check("dual/taken", {63'd0, branch_jump}, 64'd1);

    // Back-to-back: each result appears exactly one cycle later
    br_ena     = 1'b0;
    alu_op1    = 64'd10;
    alu_op2    = 64'd3;
    alu_opcode = OpSub;
    #3;
    check("b2b/hold", out_result, 64'h1020);
    @(posedge clk);
    #1;
    check("b2b/sub", out_result, 64'd7);
    alu_opcode = OpXor;
    @(posedge clk);
    #1;
    check("b2b/xor", out_result, 64'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
